// File: rtl/lfsr_hd_analyzer.sv
// Streaming Hamming-distance statistics stage for consecutive LFSR patterns.
// Accumulates HD sum/count/min/max per session and computes the average with a restoring divider.
module lfsr_hd_analyzer #(
    parameter  int W     = 8,
    parameter  int CNT_W = 8,
    localparam int HW    = $clog2(W + 1),
    localparam int SUM_W = CNT_W + HW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pat_valid,
    input  logic [W-1:0]     pat,
    output logic             pat_ready,
    input  logic             done_req,
    output logic [HW-1:0]    hd,
    output logic [SUM_W-1:0] hd_sum,
    output logic [CNT_W-1:0] run_cnt,
    output logic [HW-1:0]    hd_min,
    output logic [HW-1:0]    hd_max,
    output logic [SUM_W-1:0] avg_q,
    output logic [CNT_W-1:0] avg_r,
    output logic             busy,
    output logic             res_valid
);

    localparam int DC_W = $clog2(SUM_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [DC_W-1:0]  DIV_LAST = DC_W'(SUM_W);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DIVIDE,
        DONE
    } state_t;

    state_t state;
    logic have_prev;
    logic [W-1:0] prev;

    logic [SUM_W-1:0] div_quo;
    logic [CNT_W-1:0] div_rem;
    logic [CNT_W-1:0] div_dvs;
    logic [DC_W-1:0]  div_cnt;

    logic                    xfer;
    logic                    sample;
    logic [HW-1:0]           h;
    logic [SUM_W-1:0]        sum_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [CNT_W:0]          rem_sh;
    logic signed [CNT_W:0]   rem_diff;
    logic                    quo_bit;
    logic [CNT_W-1:0]        rem_nxt;

    function automatic logic [HW-1:0] popcount(input logic [W-1:0] v);
        logic [HW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + HW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        xfer     = (state == COLLECT) && pat_valid && pat_ready;
        sample   = xfer && have_prev;
        h        = popcount(pat ^ prev);
        sum_nxt  = sample ? hd_sum + SUM_W'(h) : hd_sum;
        cnt_nxt  = sample ? run_cnt + CNT_W'(1) : run_cnt;
        // Remainder stays below the divisor, so the sign of the trial difference decides the quotient bit.
        rem_sh   = {div_rem, div_quo[SUM_W-1]};
        rem_diff = $signed(rem_sh - {1'b0, div_dvs});
        quo_bit  = ~rem_diff[CNT_W];
        rem_nxt  = quo_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    end

    // Datapath registers carry no reset; their contents are qualified by the control state.
    always_ff @(posedge clk) begin
        if (xfer) begin
            prev <= pat;
        end
        if (state == COLLECT && done_req) begin
            div_quo <= sum_nxt;
            div_dvs <= cnt_nxt;
            div_rem <= '0;
        end else if (state == DIVIDE && div_cnt != DIV_LAST) begin
            div_quo <= {div_quo[SUM_W-2:0], quo_bit};
            div_rem <= rem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            have_prev <= 1'b0;
            hd        <= '0;
            hd_sum    <= '0;
            run_cnt   <= '0;
            hd_min    <= '0;
            hd_max    <= '0;
            avg_q     <= '0;
            avg_r     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            pat_ready <= 1'b0;
            div_cnt   <= '0;
        end else if (start) begin
            state     <= COLLECT;
            have_prev <= 1'b0;
            hd_sum    <= '0;
            run_cnt   <= '0;
            hd_min    <= HW'(W);
            hd_max    <= '0;
            avg_q     <= '0;
            avg_r     <= '0;
            busy      <= 1'b1;
            res_valid <= 1'b0;
            pat_ready <= 1'b1;
            div_cnt   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        have_prev <= 1'b1;
                    end
                    if (sample) begin
                        hd      <= h;
                        hd_sum  <= sum_nxt;
                        run_cnt <= cnt_nxt;
                        if (h < hd_min) hd_min <= h;
                        if (h > hd_max) hd_max <= h;
                    end
                    if (done_req) begin
                        state     <= DIVIDE;
                        pat_ready <= 1'b0;
                        div_cnt   <= '0;
                    end else begin
                        pat_ready <= (cnt_nxt != CNT_MAX);
                    end
                end
                DIVIDE: begin
                    // One extra cycle after the last quotient bit publishes the result.
                    if (div_cnt == DIV_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                        avg_q     <= (div_dvs == '0) ? '0 : div_quo;
                        avg_r     <= (div_dvs == '0) ? '0 : div_rem;
                    end else begin
                        div_cnt <= div_cnt + DC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_hd_analyzer.sv
// Scoreboard bench for lfsr_hd_analyzer: queue-based reference model of the HD samples,
// expected averages pushed at done_req and checked by an independent monitor.
module tb_lfsr_hd_analyzer;

    localparam int W = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pat_valid;
    logic [7:0]  pat;
    logic        pat_ready;
    logic        done_req;
    logic [3:0]  hd;
    logic [11:0] hd_sum;
    logic [7:0]  run_cnt;
    logic [3:0]  hd_min;
    logic [3:0]  hd_max;
    logic [11:0] avg_q;
    logic [7:0]  avg_r;
    logic        busy;
    logic        res_valid;

    lfsr_hd_analyzer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pat_valid (pat_valid),
        .pat       (pat),
        .pat_ready (pat_ready),
        .done_req  (done_req),
        .hd        (hd),
        .hd_sum    (hd_sum),
        .run_cnt   (run_cnt),
        .hd_min    (hd_min),
        .hd_max    (hd_max),
        .avg_q     (avg_q),
        .avg_r     (avg_r),
        .busy      (busy),
        .res_valid (res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int sum;
        int cnt;
        int mn;
        int mx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    bit         m_collect;
    bit         m_have_prev;
    logic [7:0] m_prev;
    int         m_hds[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (m_hds[i]) s += m_hds[i];
        return s;
    endfunction

    // Expected session statistics straight from the list of recorded samples.
    task automatic push_expect();
        exp_t e;
        e.cnt = m_hds.size();
        e.sum = model_sum();
        e.mn  = W;
        e.mx  = 0;
        foreach (m_hds[i]) begin
            if (m_hds[i] < e.mn) e.mn = m_hds[i];
            if (m_hds[i] > e.mx) e.mx = m_hds[i];
        end
        e.q   = (e.cnt == 0) ? 0 : e.sum / e.cnt;
        e.r   = (e.cnt == 0) ? 0 : e.sum % e.cnt;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic model_new_session();
        m_collect   = 1'b1;
        m_have_prev = 1'b0;
        m_hds.delete();
        sb.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_new_session();
        chk("start_res_valid", res_valid, 0);
        chk("start_run_cnt", run_cnt, 0);
        chk("start_hd_min", hd_min, W);
        chk("start_busy", busy, 1);
    endtask

    task automatic offer(input logic [7:0] p, input bit v, input bit d);
        bit exp_rdy;
        bit xfer;
        bit smp;
        int h;
        h       = 0;
        smp     = 1'b0;
        exp_rdy = m_collect && (m_hds.size() != 255);
        pat       = p;
        pat_valid = v;
        done_req  = d;
        chk("pat_ready", pat_ready, exp_rdy);
        xfer = v && exp_rdy;
        if (xfer) begin
            if (m_have_prev) begin
                h = $countones(p ^ m_prev);
                m_hds.push_back(h);
                smp = 1'b1;
            end
            m_prev      = p;
            m_have_prev = 1'b1;
        end
        if (d && m_collect) begin
            push_expect();
            m_collect = 1'b0;
        end
        step();
        pat_valid = 1'b0;
        done_req  = 1'b0;
        if (smp) begin
            chk("hd", hd, h);
            chk("run_cnt", run_cnt, m_hds.size());
            chk("hd_sum", hd_sum, model_sum());
        end
    endtask

    task automatic wait_result();
        int k = 0;
        while (!res_valid && k < 40) begin
            step();
            k++;
        end
        if (!res_valid) begin
            chk("res_timeout", 0, 1);
        end else begin
            chk("done_busy", busy, 0);
            chk("done_pat_ready", pat_ready, 0);
        end
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hd"}, hd, 0);
        chk({tag, "_hd_sum"}, hd_sum, 0);
        chk({tag, "_run_cnt"}, run_cnt, 0);
        chk({tag, "_hd_min"}, hd_min, 0);
        chk({tag, "_hd_max"}, hd_max, 0);
        chk({tag, "_avg_q"}, avg_q, 0);
        chk({tag, "_avg_r"}, avg_r, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_pat_ready"}, pat_ready, 0);
    endtask

    // Monitor: every rising res_valid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        bit   rv_d;
        rv_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && !rv_d) begin
                if (sb.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("avg_q", avg_q, e.q);
                    chk("avg_r", avg_r, e.r);
                    chk("res_hd_sum", hd_sum, e.sum);
                    chk("res_run_cnt", run_cnt, e.cnt);
                    chk("res_hd_min", hd_min, e.mn);
                    chk("res_hd_max", hd_max, e.mx);
                    chk("div_latency", cyc - e.cyc, 13);
                end
            end
            rv_d = res_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        pat_valid = 1'b0;
        pat       = '0;
        done_req  = 1'b0;
        m_collect = 1'b0;
        m_have_prev = 1'b0;
        m_prev    = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle_pat_ready", pat_ready, 0);

        // Basic session
        do_start();
        offer(8'h00, 1, 0);
        offer(8'hFF, 1, 0);
        offer(8'h0F, 1, 0);
        offer(8'h00, 0, 1);
        wait_result();

        // Remainder
        do_start();
        offer(8'hA5, 1, 0);
        offer(8'h5A, 1, 0);
        offer(8'h5B, 1, 0);
        offer(8'h00, 0, 1);
        wait_result();

        // Empty session
        do_start();
        offer(8'h3C, 1, 0);
        offer(8'h00, 0, 1);
        wait_result();

        // Saturation
        do_start();
        for (int i = 0; i < 256; i++) offer(8'(i % 2), 1, 0);
        offer(8'h00, 1, 0);
        chk("sat_run_cnt", run_cnt, 255);
        chk("sat_hd_sum", hd_sum, 255);
        offer(8'h00, 0, 1);
        wait_result();

        // Random handshake sessions, done_req coinciding with a transfer
        for (int s = 0; s < 4; s++) begin
            do_start();
            n = $urandom_range(2, 30);
            for (int i = 0; i < n; i++) begin
                if (i == n - 1) offer(8'($urandom), 1, 1);
                else offer(8'($urandom), bit'($urandom_range(0, 1)), 0);
            end
            wait_result();
        end

        // start together with done_req
        do_start();
        offer(8'h12, 1, 0);
        offer(8'h34, 1, 0);
        start    = 1'b1;
        done_req = 1'b1;
        step();
        start    = 1'b0;
        done_req = 1'b0;
        model_new_session();
        chk("sd_run_cnt", run_cnt, 0);
        chk("sd_busy", busy, 1);
        chk("sd_hd_min", hd_min, W);
        offer(8'hF0, 1, 0);
        offer(8'h0F, 1, 0);
        offer(8'h00, 0, 1);
        wait_result();

        // rst mid-DIVIDE
        do_start();
        offer(8'h81, 1, 0);
        offer(8'h7E, 1, 1);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        m_collect = 1'b0;
        chk_all_zero("rst_div");
        step();
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_ready", pat_ready, 0);

        // start mid-DIVIDE
        do_start();
        offer(8'h11, 1, 0);
        offer(8'hEE, 1, 0);
        offer(8'h00, 1, 1);
        repeat (4) step();
        do_start();
        chk("abort_hd_sum", hd_sum, 0);
        chk("abort_pat_ready", pat_ready, 1);
        repeat (20) step();
        chk("abort_no_res", res_valid, 0);
        offer(8'h55, 1, 0);
        offer(8'hAA, 1, 0);
        offer(8'hAB, 1, 1);
        wait_result();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_hd_analyzer.md
# lfsr_hd_analyzer

Streaming Hamming-distance analyzer that sits directly downstream of the LFSR pattern generator. It consumes the sequence of 8-bit patterns that the generator produces on each run, and computes the Hamming distance (HD) between each pair of consecutive patterns. Over a session it accumulates the HD sum, sample count, minimum and maximum. On request, a multi-cycle restoring divider produces the average HD as an integer quotient and remainder. This replaces ad-hoc combinational HD counting with a clocked, handshaked statistics stage.

## Interface

**Parameters**
- `W`, default 8: pattern width in bits.
- `CNT_W`, default 8: width of the HD sample counter.
- Derived constants:
  - `HW = $clog2(W+1)`, which is 4 at the defaults.
  - `SUM_W = CNT_W + HW`, which is 12 at the defaults.

**Ports**
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: clears the accumulators and opens a new session.
- `pat_valid`, in, 1: an LFSR pattern is offered.
- `pat`, in, W: the LFSR pattern (Q).
- `pat_ready`, out, 1: the block can accept a pattern.
- `done_req`, in, 1: closes the session and starts the average computation.
- `hd`, out, HW: HD of the most recently accepted pair.
- `hd_sum`, out, SUM_W: sum of all HD samples in the session.
- `run_cnt`, out, CNT_W: number of HD samples in the session.
- `hd_min`, out, HW: smallest HD sample in the session.
- `hd_max`, out, HW: largest HD sample in the session.
- `avg_q`, out, SUM_W: average quotient, `hd_sum / run_cnt`.
- `avg_r`, out, CNT_W: average remainder.
- `busy`, out, 1: high in COLLECT or DIVIDE.
- `res_valid`, out, 1: `avg_q` and `avg_r` are valid.

## Operation

**Reset.** On `rst`:
- state goes to IDLE;
- every output register is cleared to 0, including `hd_min`;
- the `have_prev` flag is cleared.

`rst` overrides all other inputs. Asserting it mid-session or mid-divide abandons the session with no partial results retained.

**States.** The block has four states: IDLE, COLLECT, DIVIDE and DONE.

- **IDLE**
  - `pat_ready = 0`, `busy = 0`.
  - `start` moves to COLLECT.
- **`start` from any state**
  - Applies in any non-reset state, including an abort of DIVIDE or DONE.
  - Clears `hd_sum`, `run_cnt`, `hd_max`, `avg_q`, `avg_r`, `res_valid` and `have_prev`.
  - Sets `hd_min = W`.
  - Enters COLLECT.
- **COLLECT**
  - `pat_ready = 1` unless `run_cnt == 2^CNT_W-1` (saturated), in which case `pat_ready = 0`.
  - A transfer occurs when `pat_valid & pat_ready`.
  - First transfer after `start`: `prev <= pat`, `have_prev <= 1`, and no sample is recorded.
  - Each later transfer:
    - `h = popcount(pat ^ prev)`;
    - `hd <= h`;
    - `hd_sum <= hd_sum + h`;
    - `run_cnt <= run_cnt + 1`;
    - `hd_min` and `hd_max` update;
    - `prev <= pat`.
  - `done_req` moves to DIVIDE. If `done_req` coincides with a transfer, that pattern is included first.
  - If `start` and `done_req` arrive together, `start` wins.
- **DIVIDE**
  - Restoring division of `hd_sum` by zero-extended `run_cnt`, one quotient bit per cycle, MSB first, SUM_W iterations.
  - `pat_ready = 0`.
  - `done_req` is ignored.
  - If `run_cnt == 0`, the result is `avg_q = 0`, `avg_r = 0` with unchanged latency (no divide-by-zero fault).
  - After the last iteration, go to DONE.
- **DONE**
  - `res_valid = 1`, `busy = 0`.
  - All statistics outputs are held until `start` or `rst`.

**Width rules.**
- Counter saturation caps `hd_sum` at `(2^CNT_W-1)*W`, so `hd_sum` never overflows SUM_W.
- The remainder is always less than `run_cnt`, so it fits in CNT_W.

## Timing

- **Pattern acceptance:** one pattern per cycle, with no bubbles while `pat_ready` is high.
- **Sample outputs:** `hd`, `hd_sum`, `run_cnt`, `hd_min` and `hd_max` update on the edge that samples the transfer, so they are visible the next cycle.
- **`pat_ready`:** a registered function of state and `run_cnt`. It drops the cycle after the transfer that saturates `run_cnt`.
- **Divide latency:** with `done_req` sampled at edge N:
  - `busy` stays 1 through edge N+SUM_W;
  - `res_valid` rises after edge N+SUM_W+1, i.e. 13 edges at the defaults, regardless of operand values.
- **`start` in DONE:** `res_valid` falls on the next edge.

## Test plan

- **Basic session:** reset, then `start`, patterns 0x00, 0xFF, 0x0F, then `done_req`.
  - Samples: HD 8 and HD 4.
  - Required: `hd_sum = 12`, `run_cnt = 2`, `hd_min = 4`, `hd_max = 8`, `avg_q = 6`, `avg_r = 0`.
  - `res_valid` is high exactly 13 edges after `done_req`.
- **Remainder:** `start`, patterns 0xA5, 0x5A, 0x5B, then `done_req`.
  - Samples: HD 8 and HD 1.
  - Required: `hd_sum = 9`, `run_cnt = 2`, `avg_q = 4`, `avg_r = 1`, `hd_min = 1`, `hd_max = 8`.
- **Empty session:** `start`, one pattern, then `done_req`.
  - Required: `run_cnt = 0`, `avg_q = 0`, `avg_r = 0`, `hd_min = 8`.
  - `res_valid` arrives with the same 13-edge latency.
- **Saturation:** `start`, then 256 patterns alternating 0x00/0x01.
  - Required: `run_cnt` stops at 255 and `pat_ready` drops.
  - A 257th `pat_valid` is not accepted, and `hd_sum = 255`.
  - After `done_req`: `avg_q = 1`, `avg_r = 0`.
- **Handshake and simultaneity:**
  - Toggle `pat_valid` randomly; only cycles where both `pat_valid` and `pat_ready` are high are counted.
  - `done_req` together with a transfer: that pattern's HD is included.
  - `start` together with `done_req`: a new empty session begins.
- **Abort paths:**
  - Assert `rst` mid-DIVIDE: all outputs are 0 the next cycle and state is IDLE.
  - Assert `start` mid-DIVIDE: the accumulators clear, state is COLLECT, and `res_valid` never asserts.
